pic_host_bus_master: RTL

//  CPU-side counterpart of the 8259A PIC: drives its CS/WR/RD/A0/INTA pins and data bus.

---
 rtl/pic_host_bus_master.sv | 216 +++++++++++++++++++++
 1 files changed

// File: rtl/pic_host_bus_master.sv
// pic_host_bus_master
//   CPU-side bus master for an 8259A PIC. Runs the ICW1..ICW4 init sequence,
//   issues OCW writes / status reads from a valid/ready command port, and
//   answers INT with the two-pulse INTA sequence, capturing the vector byte.
// Ports
//   clk, reset                 clock, synchronous active-high reset
//   init_start, icw1..icw4     start init (IDLE only) and the init words
//   init_done                  init sequence complete
//   cmd_valid/ready, cmd_read, cmd_a0, cmd_data   command port
//   rd_data, rd_valid          status read result
//   int_en, pic_int            INT servicing enable, INT from the PIC
//   vector, vector_valid       captured interrupt vector
//   CS_n, WR_n, RD_n, INTA_n, A0, data_out, data_oe, data_in   PIC pins
module pic_host_bus_master #(
  parameter int unsigned PULSE_CYCLES = 2,
  parameter int unsigned GAP_CYCLES   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       init_start,
  input  logic [7:0] icw1,
  input  logic [7:0] icw2,
  input  logic [7:0] icw3,
  input  logic [7:0] icw4,
  output logic       init_done,
  input  logic       cmd_valid,
  input  logic       cmd_read,
  input  logic       cmd_a0,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic [7:0] rd_data,
  output logic       rd_valid,
  input  logic       int_en,
  output logic [7:0] vector,
  output logic       vector_valid,
  input  logic       pic_int,
  output logic       CS_n,
  output logic       WR_n,
  output logic       RD_n,
  output logic       INTA_n,
  output logic       A0,
  output logic [7:0] data_out,
  output logic       data_oe,
  input  logic [7:0] data_in
);

  localparam int unsigned MAXC = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
  localparam int unsigned CW   = (MAXC < 2) ? 1 : $clog2(MAXC);

  typedef enum logic [2:0] {
    S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_INTA1, S_GAP, S_INTA2, S_RECOVER
  } state_t;

  typedef enum logic [2:0] {
    SEL_NONE, SEL_INIT, SEL_INTA, SEL_ICW, SEL_CMD
  } sel_t;

  state_t         state, state_d;
  sel_t           sel;
  logic [CW-1:0]  cnt, cnt_d;
  logic           last_pulse, last_gap;
  logic           inta_req;

  logic [7:0]     icw2_r, icw3_r, icw4_r;
  logic           sngl_r, ic4_r;
  logic [2:0]     pend_icw;   // next ICW number to write, 0 = none pending
  logic           cur_init;   // bus cycle in flight belongs to the init sequence
  logic           cur_read;
  logic           cur_a0;
  logic [7:0]     cur_data;
  logic           bus;

  // ICW following ICW n, given the SNGL and IC4 bits of ICW1.
  function automatic logic [2:0] next_icw(input logic [2:0] n, input logic sngl,
                                          input logic ic4);
    logic [2:0] r;
    r = 3'd0;
    case (n)
      3'd1:    r = 3'd2;
      3'd2:    r = !sngl ? 3'd3 : (ic4 ? 3'd4 : 3'd0);
      3'd3:    r = ic4 ? 3'd4 : 3'd0;
      default: r = 3'd0;
    endcase
    return r;
  endfunction

  function automatic logic [7:0] icw_word(input logic [2:0] n, input logic [7:0] w2,
                                          input logic [7:0] w3, input logic [7:0] w4);
    logic [7:0] r;
    r = '0;
    case (n)
      3'd2:    r = w2;
      3'd3:    r = w3;
      3'd4:    r = w4;
      default: r = '0;
    endcase
    return r;
  endfunction

  assign last_pulse = (cnt == CW'(PULSE_CYCLES - 1));
  assign last_gap   = (cnt == CW'(GAP_CYCLES - 1));
  assign inta_req   = pic_int & int_en & init_done;
  assign cmd_ready  = (state == S_IDLE) & init_done & ~inta_req & ~init_start &
                      (pend_icw == 3'd0);

  always_comb begin
    state_d = state;
    cnt_d   = cnt + CW'(1);
    sel     = SEL_NONE;
    case (state)
      S_IDLE: begin
        cnt_d = '0;
        if (init_start) begin
          sel = SEL_INIT; state_d = S_SETUP;
        end else if (inta_req) begin
          sel = SEL_INTA; state_d = S_INTA1;
        end else if (pend_icw != 3'd0) begin
          sel = SEL_ICW; state_d = S_SETUP;
        end else if (cmd_valid && cmd_ready) begin
          sel = SEL_CMD; state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        cnt_d = '0; state_d = S_STROBE;
      end
      S_STROBE: if (last_pulse) begin cnt_d = '0; state_d = S_HOLD; end
      S_HOLD: begin
        cnt_d = '0; state_d = S_IDLE;
      end
      S_INTA1:   if (last_pulse) begin cnt_d = '0; state_d = S_GAP; end
      S_GAP:     if (last_gap)   begin cnt_d = '0; state_d = S_INTA2; end
      S_INTA2:   if (last_pulse) begin cnt_d = '0; state_d = S_RECOVER; end
      S_RECOVER: if (last_gap)   begin cnt_d = '0; state_d = S_IDLE; end
      default: begin
        cnt_d = '0; state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= S_IDLE;
      cnt          <= '0;
      icw2_r       <= '0;
      icw3_r       <= '0;
      icw4_r       <= '0;
      sngl_r       <= 1'b0;
      ic4_r        <= 1'b0;
      pend_icw     <= 3'd0;
      cur_init     <= 1'b0;
      cur_read     <= 1'b0;
      cur_a0       <= 1'b0;
      cur_data     <= '0;
      init_done    <= 1'b0;
      rd_data      <= '0;
      rd_valid     <= 1'b0;
      vector       <= '0;
      vector_valid <= 1'b0;
    end else begin
      state        <= state_d;
      cnt          <= cnt_d;
      rd_valid     <= 1'b0;
      vector_valid <= 1'b0;
      case (sel)
        SEL_INIT: begin
          // ICW1 goes out straight away from the port; later words from the copies.
          icw2_r    <= icw2;
          icw3_r    <= icw3;
          icw4_r    <= icw4;
          sngl_r    <= icw1[1];
          ic4_r     <= icw1[0];
          init_done <= 1'b0;
          pend_icw  <= 3'd2;
          cur_init  <= 1'b1;
          cur_read  <= 1'b0;
          cur_a0    <= 1'b0;
          cur_data  <= icw1;
        end
        SEL_ICW: begin
          pend_icw  <= next_icw(pend_icw, sngl_r, ic4_r);
          cur_init  <= 1'b1;
          cur_read  <= 1'b0;
          cur_a0    <= 1'b1;
          cur_data  <= icw_word(pend_icw, icw2_r, icw3_r, icw4_r);
        end
        SEL_CMD: begin
          cur_init  <= 1'b0;
          cur_read  <= cmd_read;
          cur_a0    <= cmd_a0;
          cur_data  <= cmd_read ? 8'h00 : cmd_data;
        end
        default: ;
      endcase
      if (state == S_STROBE && last_pulse && cur_read) begin
        rd_data  <= data_in;
        rd_valid <= 1'b1;
      end
      if (state == S_HOLD && cur_init && pend_icw == 3'd0)
        init_done <= 1'b1;
      if (state == S_INTA2 && last_pulse) begin
        vector       <= data_in;
        vector_valid <= 1'b1;
      end
    end
  end

  assign bus      = (state == S_SETUP) | (state == S_STROBE) | (state == S_HOLD);
  assign CS_n     = ~bus;
  assign WR_n     = ~((state == S_STROBE) & ~cur_read);
  assign RD_n     = ~((state == S_STROBE) & cur_read);
  assign INTA_n   = ~((state == S_INTA1) | (state == S_INTA2));
  assign A0       = bus & cur_a0;
  assign data_oe  = bus & ~cur_read;
  assign data_out = data_oe ? cur_data : 8'h00;

endmodule
